dolphin_ctrl: RTL

- Command source that sits directly upstream of the 4-bit up/down counter.
- Loads the counter limit (load_en/count_to), then issues paced single-cycle count_inc/count_dec pulses.
- Closes the loop on the counter's flag_max/flag_min, reversing direction at each end ("dolphin" bounce) and counting bounces.
- A stop request or a bounce limit returns it to idle.

---
 rtl/dolphin_pkg.sv | 16 +
 rtl/dolphin_if.sv | 23 ++
 rtl/tick_gen.sv | 33 +++
 rtl/dolphin_ctrl.sv | 149 ++++++++++++++
 4 files changed

// File: rtl/dolphin_pkg.sv
// Shared types and default sizing for the dolphin bounce controller.
package dolphin_pkg;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SETTLE,
        UP,
        DOWN
    } state_t;

    localparam int DEF_WIDTH    = 4;
    localparam int DEF_TICK_DIV = 4;
    localparam int DEF_BW       = 8;

endpackage

// File: rtl/dolphin_if.sv
// Command/flag bus between the dolphin controller and the up/down counter.
interface dolphin_if #(
    parameter int WIDTH = 4
);

    logic             load_en;
    logic [WIDTH-1:0] count_to;
    logic             count_inc;
    logic             count_dec;
    logic             flag_max;
    logic             flag_min;

    modport master (
        output load_en, count_to, count_inc, count_dec,
        input  flag_max, flag_min
    );

    modport slave (
        input  load_en, count_to, count_inc, count_dec,
        output flag_max, flag_min
    );

endinterface

// File: rtl/tick_gen.sv
// Free-running prescaler: one tick every TICK_DIV enabled cycles.
module tick_gen #(
    parameter int TICK_DIV = 4
) (
    input  logic clk,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int CW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(TICK_DIV - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    always_comb begin
        tick  = en && !clr && (cnt_q == LAST);
        cnt_d = cnt_q;
        if (clr)
            cnt_d = '0;
        else if (en)
            cnt_d = tick ? '0 : cnt_q + 1'b1;
    end

    always_ff @(posedge clk) begin
        if (reset)
            cnt_q <= '0;
        else
            cnt_q <= cnt_d;
    end

endmodule

// File: rtl/dolphin_ctrl.sv
// Drives the up/down counter back and forth between 0 and the limit,
// counting reversals and auto-stopping after bounce_max of them.
module dolphin_ctrl
    import dolphin_pkg::*;
#(
    parameter int WIDTH    = DEF_WIDTH,
    parameter int TICK_DIV = DEF_TICK_DIV,
    parameter int BW       = DEF_BW
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic             stop,
    input  logic             limit_wr,
    input  logic [WIDTH-1:0] limit_in,
    input  logic [BW-1:0]    bounce_max,
    dolphin_if.master        bus,
    output logic             dir,
    output logic             busy,
    output logic [BW-1:0]    bounces,
    output logic             done
);

    state_t           state_q, state_d;
    logic [WIDTH-1:0] limit_q, limit_d;
    logic [BW-1:0]    bnc_q, bnc_d;
    logic             load_q, load_d;
    logic             inc_q, inc_d;
    logic             dec_q, dec_d;
    logic             dir_q, dir_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             fin_q, fin_d;
    logic             run, tick, rev;

    assign run = (state_q == UP) || (state_q == DOWN);

    tick_gen #(.TICK_DIV(TICK_DIV)) u_tick (
        .clk   (clk),
        .reset (reset),
        .clr   (!run || stop || fin_q),
        .en    (run),
        .tick  (tick)
    );

    always_comb begin
        state_d = state_q;
        limit_d = limit_q;
        bnc_d   = bnc_q;
        load_d  = 1'b0;
        inc_d   = 1'b0;
        dec_d   = 1'b0;
        dir_d   = dir_q;
        done_d  = 1'b0;
        fin_d   = 1'b0;
        rev     = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (limit_wr)
                    limit_d = limit_in;
                if (start && !stop) begin
                    state_d = LOAD;
                    load_d  = 1'b1;
                    bnc_d   = '0;
                    dir_d   = 1'b1;
                end
            end
            LOAD:   state_d = SETTLE;
            SETTLE: state_d = UP;
            UP, DOWN: begin
                // fin_q marks the cycle after the final reversal pulse
                if (fin_q) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end else if (tick) begin
                    if (state_q == UP) begin
                        if (!bus.flag_max) begin
                            inc_d = 1'b1;
                        end else begin
                            dec_d   = 1'b1;
                            dir_d   = 1'b0;
                            state_d = DOWN;
                            rev     = 1'b1;
                        end
                    end else begin
                        if (!bus.flag_min) begin
                            dec_d = 1'b1;
                        end else begin
                            inc_d   = 1'b1;
                            dir_d   = 1'b1;
                            state_d = UP;
                            rev     = 1'b1;
                        end
                    end
                    if (rev) begin
                        bnc_d = bnc_q + 1'b1;
                        fin_d = (bounce_max != '0) && (bnc_d == bounce_max);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
        if (stop && state_q != IDLE) begin
            state_d = IDLE;
            load_d  = 1'b0;
            inc_d   = 1'b0;
            dec_d   = 1'b0;
            done_d  = 1'b0;
            fin_d   = 1'b0;
        end
        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            limit_q <= '1;
            bnc_q   <= '0;
            load_q  <= 1'b0;
            inc_q   <= 1'b0;
            dec_q   <= 1'b0;
            dir_q   <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            fin_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            limit_q <= limit_d;
            bnc_q   <= bnc_d;
            load_q  <= load_d;
            inc_q   <= inc_d;
            dec_q   <= dec_d;
            dir_q   <= dir_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            fin_q   <= fin_d;
        end
    end

    assign bus.load_en   = load_q;
    assign bus.count_to  = limit_q;
    assign bus.count_inc = inc_q;
    assign bus.count_dec = dec_q;
    assign dir           = dir_q;
    assign busy          = busy_q;
    assign bounces       = bnc_q;
    assign done          = done_q;

endmodule
